bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential shift-add-3 (double-dabble) binary-to-BCD converter that sits directly downstream of the menu/data-selection stage.
- Consumes the selected 16-bit display value and its decimal-point pattern.
- Produces packed BCD digits for the 7-segment driver.
- Uses a ready/valid handshake.
- Performs one shift per clock, giving a small iterative datapath instead of a combinational converter.

Parameters:
IN_WIDTH, 16, width of the binary input value.
DIGITS, 5, number of BCD output digits. DIGITS*4 must hold 2^IN_WIDTH-1; this is an integration constraint and is not checked in RTL.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  bin_in/dp_in valid for conversion
in_ready  output  1  converter idle, can accept a new value
bin_in  input  IN_WIDTH  unsigned binary value to convert
dp_in  input  4  decimal-point pattern, carried alongside the value
out_valid  output  1  one-cycle pulse when bcd_out/dp_out/over_range update
bcd_out  output  DIGITS*4  packed BCD; digit 0 in [3:0], digit 1 in [7:4], and so on
dp_out  output  4  dp_in captured with the value now on bcd_out
over_range  output  1  result exceeds 9999, i.e. any digit index >= 4 is nonzero
busy  output  1  conversion in progress, equal to ~in_ready

Behaviour:
Reset (synchronous, highest priority):
- State = IDLE.
- bcd_out = 0, dp_out = 0, over_range = 0, out_valid = 0.
- Shift registers and iteration counter cleared.
- in_ready = 1 in the first cycle after reset.
- Reset during SHIFT or DONE aborts the conversion: no out_valid, and the previous result is discarded (outputs zeroed).

State machine: IDLE, SHIFT, DONE.

IDLE:
- in_ready = 1.
- When in_valid = 1 at an edge:
  - capture bin_in into the binary shift register;
  - capture dp_in into dp_hold;
  - clear the BCD working register and counter to 0;
  - go to SHIFT.
- When in_valid = 0, stay in IDLE.

SHIFT:
- in_ready = 0. in_valid and bin_in are ignored.
- Each edge, in this order:
  1. For each working BCD digit >= 5, add 3 (4-bit result, no carry between digits).
  2. Shift {bcd_work, bin_shift} left by 1; the binary MSB enters BCD bit 0; bin_shift LSB fills with 0.
  3. Increment the counter.
- When the counter reaches IN_WIDTH-1 at the current edge (i.e. on the IN_WIDTH-th shift), go to DONE.

DONE:
- in_ready = 0.
- On the next edge:
  - bcd_out <= bcd_work;
  - dp_out <= dp_hold;
  - over_range <= (bcd_work[DIGITS*4-1:16] != 0);
  - out_valid <= 1;
  - go to IDLE.

out_valid:
- High for exactly one cycle.
- That cycle coincides with in_ready = 1.

Latency and throughput:
- Accept edge at k; out_valid is high in the cycle after edge k+IN_WIDTH+1, which is 17 edges for the default IN_WIDTH.
- When in_valid is held high, the next accept happens at the edge that raises out_valid+1. This gives one result per IN_WIDTH+2 = 18 cycles.

Output hold and ordering:
- bcd_out, dp_out and over_range hold their last values until the next completion. They never show partial results.
- An input held constant is reconverted each time; no change detection is performed.

Boundary values:
- bin_in = 0 produces all-zero digits.
- bin_in = 2^IN_WIDTH-1 converts exactly.
- The counter has clog2(IN_WIDTH) bits and must not wrap before the DONE transition.

Test Plan:
- Reset, then in_valid with bin_in = 0, dp_in = 4'b0000: out_valid pulses 17 cycles after accept; bcd_out = 20'h00000, over_range = 0.
- bin_in = 16'd65535, dp_in = 4'b1000: bcd_out = 20'h65535, dp_out = 4'b1000, over_range = 1.
- bin_in = 9999, then bin_in = 10000: first gives bcd_out = 20'h09999 with over_range = 0; second gives 20'h10000 with over_range = 1.
- in_valid held high with bin_in = 1234, and bin_in changed to 4321 while busy: the first result is 20'h01234 (mid-conversion change ignored); the next accept occurs in the out_valid cycle; results are spaced 18 cycles apart; the second result is 20'h04321.
- Complete a conversion of 42, then start 777 and assert reset at shift 8 for one cycle: no out_valid; bcd_out = 0 and dp_out = 0 after reset; in_ready = 1 next cycle; a following conversion of 777 gives 20'h00777.
- Random sweep of 1000 values, compared against a reference decimal model: every bcd_out digit matches, and out_valid count equals accept count.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter, one shift per clock,
// with a ready/valid input handshake and a one-cycle out_valid pulse per result.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   bin_in,
  input  logic [3:0]            dp_in,
  output logic                  out_valid,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic [3:0]            dp_out,
  output logic                  over_range,
  output logic                  busy
);
  localparam int BW = DIGITS * 4;
  localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state;
  logic [IN_WIDTH-1:0] bin_shift;
  logic [BW-1:0]       bcd_work;
  logic [BW-1:0]       bcd_adj;
  logic [3:0]          dp_hold;
  logic [CW-1:0]       cnt;
  // add-3 correction per digit before each shift; digits never carry into each other
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = (bcd_work[4*i +: 4] >= 4'd5) ? bcd_work[4*i +: 4] + 4'd3 : bcd_work[4*i +: 4];
  end
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bin_shift  <= '0;
      bcd_work   <= '0;
      dp_hold    <= '0;
      cnt        <= '0;
      bcd_out    <= '0;
      dp_out     <= '0;
      over_range <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          bin_shift <= bin_in;
          dp_hold   <= dp_in;
          bcd_work  <= '0;
          cnt       <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          bcd_work  <= {bcd_adj[BW-2:0], bin_shift[IN_WIDTH-1]};
          bin_shift <= bin_shift << 1;
          cnt       <= cnt + 1'b1;
          state     <= (cnt == CW'(IN_WIDTH - 1)) ? DONE : SHIFT;
        end
        DONE: begin
          bcd_out    <= bcd_work;
          dp_out     <= dp_hold;
          over_range <= |bcd_work[BW-1:16];
          out_valid  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: table-driven and directed checks of the sequential BCD converter,
// plus a random sweep against a decimal reference model.
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] bin_in = '0;
  logic [3:0]  dp_in = '0;
  logic        out_valid;
  logic [19:0] bcd_out;
  logic [3:0]  dp_out;
  logic        over_range;
  logic        busy;
  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_ov = 0;
  always #5 clk = ~clk;
  bin_to_bcd_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .dp_in(dp_in), .out_valid(out_valid), .bcd_out(bcd_out),
    .dp_out(dp_out), .over_range(over_range), .busy(busy)
  );
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) n_acc++;
    if (out_valid) n_ov++;
  end
  typedef struct {
    logic [15:0] bin;
    logic [3:0]  dp;
    logic [19:0] bcd;
    logic        ovr;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  // one full handshake; checks ready, busy, latency and all result fields
  task automatic convert(input logic [15:0] b, input logic [3:0] d,
                         input logic [19:0] e_bcd, input logic e_ovr, input bit full);
    int m;
    @(negedge clk);
    if (full) chk("ready_before_accept", in_ready, 1);
    in_valid = 1'b1; bin_in = b; dp_in = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (full) chk("busy_after_accept", busy, 1);
    m = 0;
    while (!out_valid && m < 40) begin
      @(negedge clk);
      m++;
    end
    if (full) chk("latency", m, 17);
    else if (m >= 40) chk("timeout", m, 17);
    chk("bcd_out", bcd_out, e_bcd);
    chk("dp_out", dp_out, d);
    chk("over_range", over_range, e_ovr);
    if (full) chk("ready_with_valid", in_ready, 1);
    @(negedge clk);
    if (full) chk("valid_one_cycle", out_valid, 0);
  endtask
  initial begin
    int m, a0, o0;
    logic [15:0] v;
    vecs[0] = '{16'd0,     4'b0000, 20'h00000, 1'b0};
    vecs[1] = '{16'd65535, 4'b1000, 20'h65535, 1'b1};
    vecs[2] = '{16'd9999,  4'b0100, 20'h09999, 1'b0};
    vecs[3] = '{16'd10000, 4'b0010, 20'h10000, 1'b1};
    vecs[4] = '{16'd1,     4'b0001, 20'h00001, 1'b0};
    vecs[5] = '{16'd10,    4'b1111, 20'h00010, 1'b0};
    vecs[6] = '{16'd4096,  4'b0011, 20'h04096, 1'b0};
    vecs[7] = '{16'd59999, 4'b1010, 20'h59999, 1'b1};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_bcd", bcd_out, 0);
    chk("reset_dp", dp_out, 0);
    chk("reset_ovr", over_range, 0);
    for (int i = 0; i < 8; i++) convert(vecs[i].bin, vecs[i].dp, vecs[i].bcd, vecs[i].ovr, 1);
    // in_valid held high, input changed mid-conversion, back-to-back spacing
    @(negedge clk);
    in_valid = 1'b1; bin_in = 16'd1234; dp_in = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    bin_in = 16'd4321; dp_in = 4'b0110;
    m = 0;
    while (!out_valid && m < 40) begin @(negedge clk); m++; end
    chk("held_latency", m, 17);
    chk("held_first_bcd", bcd_out, 20'h01234);
    chk("held_first_dp", dp_out, 4'b0001);
    chk("held_ready", in_ready, 1);
    @(negedge clk);
    m = 1;
    while (!out_valid && m < 40) begin @(negedge clk); m++; end
    in_valid = 1'b0;
    chk("held_spacing", m, 18);
    chk("held_second_bcd", bcd_out, 20'h04321);
    chk("held_second_dp", dp_out, 4'b0110);
    repeat (3) @(negedge clk);
    // reset mid-conversion discards the result
    convert(16'd42, 4'b0100, 20'h00042, 1'b0, 1);
    @(negedge clk);
    in_valid = 1'b1; bin_in = 16'd777; dp_in = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_bcd", bcd_out, 0);
    chk("abort_dp", dp_out, 0);
    chk("abort_ready", in_ready, 1);
    m = 0;
    repeat (20) begin @(negedge clk); if (out_valid) m++; end
    chk("abort_no_valid", m, 0);
    convert(16'd777, 4'b0101, 20'h00777, 1'b0, 1);
    // random sweep against decimal model
    a0 = n_acc; o0 = n_ov;
    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom_range(0, 65535));
      convert(v, 4'($urandom_range(0, 15)), ref_bcd(int'(v)), v > 16'd9999, 0);
    end
    chk("sweep_accepts", n_acc - a0, 1000);
    chk("sweep_valids", n_ov - o0, 1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
